// File: rtl/to_fp9_conv_pipe.sv
// Converts packed FP4 (E2M1), FP8 (E4M3/E5M2) or FP16 input beats into
// packed 9-bit E5M3 lanes, with valid/ready handshakes on both sides.
// FP4 beats expand into two output beats.
// Pairs of FP16 beats merge into one output beat.
module to_fp9_conv_pipe #(
  parameter int unsigned BUS_W        = 32,
  parameter logic [4:0]  FP4_CODE     = 5'd1,
  parameter logic [4:0]  FP8_CODE     = 5'd2,
  parameter logic [4:0]  FP16_CODE    = 5'd4,
  parameter logic [2:0]  FP8E4M3_CODE = 3'd0,
  parameter logic [2:0]  FP8E5M2_CODE = 3'd1,
  localparam int unsigned LANES       = BUS_W / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           type_ab,
  input  logic [2:0]           type_ab_sub,
  input  logic [BUS_W-1:0]     in,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [LANES*9-1:0]   out,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 err_o
);

  localparam int unsigned OUT_W  = LANES * 9;
  localparam int unsigned HALF_W = (LANES / 2) * 9;

  typedef enum logic [1:0] {IDLE, FP4_HI, FP16_HALF} state_t;

  state_t             state, state_d;
  logic [OUT_W-1:0]   out_d, hi_buf, hi_d;
  logic [HALF_W-1:0]  half_buf, half_d;
  logic               valid_d, err_d;

  logic [OUT_W-1:0]   fp8_lanes, fp4_lo, fp4_hi;
  logic [HALF_W-1:0]  fp16_conv;

  logic accept, out_fire, is_fp4, is_fp8, is_fp16, sub_e4m3;

  // Field widening into {sign, exp[4:0], man[2:0]}
  function automatic logic [8:0] cvt_fp4(input logic [3:0] v);
    return {v[3], 3'b000, v[2:1], v[0], 2'b00};
  endfunction

  function automatic logic [8:0] cvt_e4m3(input logic [7:0] v);
    return {v[7], 1'b0, v[6:3], v[2:0]};
  endfunction

  function automatic logic [8:0] cvt_e5m2(input logic [7:0] v);
    return {v[7], v[6:2], v[1:0], 1'b0};
  endfunction

  // Takes sign, exponent and the top three mantissa bits; the rest is truncated
  function automatic logic [8:0] cvt_fp16(input logic [8:0] v);
    return v;
  endfunction

  assign sub_e4m3 = (type_ab_sub == FP8E4M3_CODE);
  assign is_fp4   = (type_ab == FP4_CODE);
  assign is_fp16  = (type_ab == FP16_CODE);
  assign is_fp8   = (type_ab == FP8_CODE) &&
                    (sub_e4m3 || (type_ab_sub == FP8E5M2_CODE));

  assign out_fire   = out_valid_o && out_ready_i;
  assign in_ready_o = (state != FP4_HI) && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Per-lane conversion of the current input beat for every supported format
  always_comb begin
    fp8_lanes = '0;
    fp4_lo    = '0;
    fp4_hi    = '0;
    fp16_conv = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      fp8_lanes[9*k +: 9] = sub_e4m3 ? cvt_e4m3(in[8*k +: 8]) : cvt_e5m2(in[8*k +: 8]);
      fp4_lo[9*k +: 9]    = cvt_fp4(in[4*k +: 4]);
      fp4_hi[9*k +: 9]    = cvt_fp4(in[4*(k+LANES) +: 4]);
    end
    for (int unsigned k = 0; k < LANES / 2; k++) begin
      fp16_conv[9*k +: 9] = cvt_fp16(in[16*k+7 +: 9]);
    end
  end

  // Next-state, output register and buffer updates
  always_comb begin
    state_d = state;
    out_d   = out;
    valid_d = out_valid_o;
    err_d   = 1'b0;
    hi_d    = hi_buf;
    half_d  = half_buf;
    if (out_fire) valid_d = 1'b0;
    if (state == FP4_HI) begin
      if (out_fire) begin
        out_d   = hi_buf;
        valid_d = 1'b1;
        hi_d    = '0;
        state_d = IDLE;
      end
    end else if (accept) begin
      if (is_fp16) begin
        if (state == FP16_HALF) begin
          out_d   = {fp16_conv, half_buf};
          valid_d = 1'b1;
          half_d  = '0;
          state_d = IDLE;
        end else begin
          half_d  = fp16_conv;
          state_d = FP16_HALF;
        end
      end else if (is_fp4 || is_fp8) begin
        // A non-FP16 beat orphans any buffered FP16 half, then runs as from IDLE
        if (state == FP16_HALF) begin
          err_d  = 1'b1;
          half_d = '0;
        end
        valid_d = 1'b1;
        if (is_fp4) begin
          out_d   = fp4_lo;
          hi_d    = fp4_hi;
          state_d = FP4_HI;
        end else begin
          out_d   = fp8_lanes;
          state_d = IDLE;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State, output and buffer registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out         <= '0;
      out_valid_o <= 1'b0;
      err_o       <= 1'b0;
      hi_buf      <= '0;
      half_buf    <= '0;
    end else begin
      state       <= state_d;
      out         <= out_d;
      out_valid_o <= valid_d;
      err_o       <= err_d;
      hi_buf      <= hi_d;
      half_buf    <= half_d;
    end
  end

endmodule
